icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 9 +
 rtl/icache_data_array.sv | 21 ++
 rtl/icache.sv | 111 +++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and default geometry for the direct-mapped instruction cache.
package icache_pkg;
    localparam int NUM_LINES_DEF      = 16;
    localparam int WORDS_PER_LINE_DEF = 4;
    localparam int OFFSET_W           = $clog2(WORDS_PER_LINE_DEF);
    localparam int INDEX_W            = $clog2(NUM_LINES_DEF);
    localparam int TAG_W              = 30 - OFFSET_W - INDEX_W;
    typedef enum logic [1:0] {S_IDLE, S_RESP, S_REFILL, S_FILL} state_t;
endpackage

// File: rtl/icache_data_array.sv
// icache_data_array: line word storage, one synchronous write port and one combinational read port.
module icache_data_array #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                              clk,
    input  logic                              we_i,
    input  logic [$clog2(NUM_LINES)-1:0]      widx_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wword_i,
    input  logic [31:0]                       wdata_i,
    input  logic [$clog2(NUM_LINES)-1:0]      ridx_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rword_i,
    output logic [31:0]                       rdata_o
);
    logic [31:0] mem_q [NUM_LINES*WORDS_PER_LINE];

    always_ff @(posedge clk)
        if (we_i) mem_q[{widx_i, wword_i}] <= wdata_i;

    assign rdata_o = mem_q[{ridx_i, rword_i}];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with 4-beat line refill and global invalidate.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = NUM_LINES_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_en_i,
    input  logic [31:0] icache_addr_i,
    output logic [31:0] icache_rdata_o,
    output logic        icache_rvalid_o,
    input  logic        inv_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 30 - OW - IW;

    state_t               state_q, state_d;
    logic [31:0]          req_addr_q, req_addr_d, rdata_q, rdata_d, rd_word;
    logic [OW-1:0]        beat_q, beat_d, lk_off;
    logic                 inv_pend_q, inv_pend_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]        tag_q [NUM_LINES];
    logic [TW-1:0]        lk_tag;
    logic [IW-1:0]        lk_idx, f_idx;
    logic                 hit, fill_we, last, unused;

    assign lk_off  = icache_addr_i[2 +: OW];
    assign lk_idx  = icache_addr_i[2+OW +: IW];
    assign lk_tag  = icache_addr_i[31 -: TW];
    assign f_idx   = req_addr_q[2+OW +: IW];
    assign hit     = valid_q[lk_idx] && tag_q[lk_idx] == lk_tag;
    assign fill_we = state_q == S_FILL && mem_rvalid_i;
    assign last    = fill_we && beat_q == '1;
    assign unused  = ^{icache_addr_i[1:0], req_addr_q[1:0]};

    icache_data_array #(.NUM_LINES(NUM_LINES), .WORDS_PER_LINE(WORDS_PER_LINE)) u_data (
        .clk     (clk),
        .we_i    (fill_we),
        .widx_i  (f_idx),
        .wword_i (beat_q),
        .wdata_i (mem_rdata_i),
        .ridx_i  (lk_idx),
        .rword_i (lk_off),
        .rdata_o (rd_word)
    );

    assign icache_rvalid_o = state_q == S_RESP && icache_en_i && icache_addr_i[31:2] == req_addr_q[31:2];
    assign icache_rdata_o  = rdata_q;
    assign mem_req_o       = state_q == S_REFILL;
    assign mem_addr_o      = {req_addr_q[31:OW+2], {(OW+2){1'b0}}};

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        rdata_d    = rdata_q;
        beat_d     = beat_q;
        inv_pend_d = inv_pend_q || (inv_i && (state_q == S_REFILL || state_q == S_FILL));
        valid_d    = inv_i ? '0 : valid_q;
        case (state_q)
            S_IDLE: if (icache_en_i) begin
                req_addr_d = icache_addr_i;
                inv_pend_d = 1'b0;
                state_d    = hit ? S_RESP : S_REFILL;
                rdata_d    = hit ? rd_word : rdata_q;
            end
            S_RESP: state_d = S_IDLE;
            S_REFILL: if (mem_gnt_i) begin
                state_d = S_FILL;
                beat_d  = '0;
            end
            S_FILL: if (mem_rvalid_i) begin
                beat_d  = beat_q + 1'b1;
                rdata_d = beat_q == req_addr_q[2 +: OW] ? mem_rdata_i : rdata_q;
                if (last) begin
                    state_d = S_RESP;
                    // an invalidate anywhere in the refill keeps the new line invalid
                    if (!inv_i && !inv_pend_q) valid_d[f_idx] = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            rdata_q    <= '0;
            beat_q     <= '0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            rdata_q    <= rdata_d;
            beat_q     <= beat_d;
            inv_pend_q <= inv_pend_d;
            valid_q    <= valid_d;
        end

    always_ff @(posedge clk)
        if (last) tag_q[f_idx] <= req_addr_q[31 -: TW];
endmodule
